// File: rtl/dma_desc_sched_if.sv
// Shared descriptor/status/error types and the scheduler's bus bundle
// (requester side, engine side and completion side).
package dma_desc_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic done;
    logic error;
  } s_dma_status_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  code;
  } s_dma_error_t;
endpackage

interface dma_desc_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  import dma_desc_pkg::*;
  localparam int CH_W = $clog2(NUM_CH);

  logic        [NUM_CH-1:0] req_valid_i;
  s_dma_desc_t [NUM_CH-1:0] req_desc_i;
  logic        [NUM_CH-1:0] req_ready_o;
  logic                     dma_go_o;
  s_dma_desc_t              dma_desc_o;
  s_dma_status_t            dma_stats_i;
  s_dma_error_t             dma_error_i;
  logic        [NUM_CH-1:0] cpl_valid_o;
  logic                     cpl_err_o;
  s_dma_error_t             cpl_err_info_o;
  logic        [CNT_W-1:0]  cpl_cycles_o;
  logic                     busy_o;
  logic        [CH_W-1:0]   cur_ch_o;

  // slave: the scheduler; master: requesters plus engine driving it
  modport slave (
    input  req_valid_i, req_desc_i, dma_stats_i, dma_error_i,
    output req_ready_o, dma_go_o, dma_desc_o, cpl_valid_o, cpl_err_o,
           cpl_err_info_o, cpl_cycles_o, busy_o, cur_ch_o
  );
  modport master (
    output req_valid_i, req_desc_i, dma_stats_i, dma_error_i,
    input  req_ready_o, dma_go_o, dma_desc_o, cpl_valid_o, cpl_err_o,
           cpl_err_info_o, cpl_cycles_o, busy_o, cur_ch_o
  );
endinterface

// File: rtl/dma_desc_sched.sv
// Round-robin descriptor scheduler feeding a single DMA engine over a go/done
// handshake; one job in flight, per-channel completion with error and cycle count.
module dma_desc_sched_lane #(
  parameter int CH_W = 2,
  parameter int IDX  = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            grant,
  input  logic [CH_W-1:0] sel,
  input  logic            fire,
  input  logic [CH_W-1:0] cur_ch,
  output logic            req_ready,
  output logic            cpl_valid
);
  assign req_ready = grant && (sel == CH_W'(IDX));

  always_ff @(posedge clk) begin
    if (!rstn) cpl_valid <= 1'b0;
    else       cpl_valid <= fire && (cur_ch == CH_W'(IDX));
  end
endmodule

module dma_desc_sched
  import dma_desc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input logic          clk,
  input logic          rstn,
  dma_desc_sched_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr, sel, cur_ch;
  logic              found, grant, fire;
  logic              go_q, busy_q, job_err, cpl_err;
  s_dma_desc_t       desc_q;
  s_dma_error_t      job_info, cpl_info, info_next;
  logic [CNT_W-1:0]  job_cnt, cnt_next, cpl_cycles;
  logic [NUM_CH-1:0] ready_v, cpl_v;
  int                idx;

  // first pending channel at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && bus.req_valid_i[idx[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[CH_W-1:0];
      end
    end
  end

  assign grant     = (state == S_IDLE) && found && rstn;
  assign fire      = (state == S_BUSY) && bus.dma_stats_i.done;
  assign cnt_next  = (&job_cnt) ? job_cnt : job_cnt + CNT_W'(1);
  // only the first error of a job is recorded; later ones just keep the flag set
  assign info_next = (bus.dma_stats_i.error && !job_err) ? bus.dma_error_i : job_info;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    dma_desc_sched_lane #(.CH_W(CH_W), .IDX(i)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .grant     (grant),
      .sel       (sel),
      .fire      (fire),
      .cur_ch    (cur_ch),
      .req_ready (ready_v[i]),
      .cpl_valid (cpl_v[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      desc_q     <= '0;
      job_err    <= 1'b0;
      job_info   <= '0;
      job_cnt    <= '0;
      cpl_err    <= 1'b0;
      cpl_info   <= '0;
      cpl_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          desc_q   <= bus.req_desc_i[sel];
          cur_ch   <= sel;
          rr_ptr   <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
          job_err  <= 1'b0;
          job_info <= '0;
          job_cnt  <= '0;
          go_q     <= 1'b1;
          busy_q   <= 1'b1;
          state    <= S_BUSY;
        end
        S_BUSY: begin
          job_cnt  <= cnt_next;
          job_info <= info_next;
          if (bus.dma_stats_i.error) job_err <= 1'b1;
          if (bus.dma_stats_i.done) begin
            // error seen on the done cycle still belongs to this job
            cpl_err    <= job_err | bus.dma_stats_i.error;
            cpl_info   <= info_next;
            cpl_cycles <= cnt_next;
            go_q       <= 1'b0;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = ready_v;
  assign bus.cpl_valid_o    = cpl_v;
  assign bus.dma_go_o       = go_q;
  assign bus.dma_desc_o     = desc_q;
  assign bus.cpl_err_o      = cpl_err;
  assign bus.cpl_err_info_o = cpl_info;
  assign bus.cpl_cycles_o   = cpl_cycles;
  assign bus.busy_o         = busy_q;
  assign bus.cur_ch_o       = cur_ch;
endmodule
